// File: rtl/stoch_div_scheduler.sv
// stoch_div_scheduler
//   Time-shares one stochastic fixed-gain divide datapath among NUM_CH
//   requester bitstreams. Each channel owns a residual accumulator and a
//   programmable integer gain. A round-robin arbiter grants one requesting
//   channel per cycle, and that channel's context takes one divide step.
//
// Ports
//   CLK       clock
//   nRST      synchronous active-low reset
//   req       per-channel request; req[i] means a[i] holds a valid bit
//   a         per-channel stochastic input bit
//   ack       one-hot (or zero) grant, combinational; a[i] consumed when ack[i]
//   cfg_we    gain write strobe
//   cfg_id    channel addressed by cfg_we
//   cfg_gain  new gain (0 is stored as 1)
//   y         divided output bit, registered
//   y_valid   y / y_id valid this cycle, registered
//   y_id      channel that produced y, registered
module stoch_div_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int COUNTER_SIZE = 8,
    parameter int GAIN_W       = 8,
    parameter int RESET_GAIN   = 2,
    localparam int ID_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic [NUM_CH-1:0] req,
    input  logic [NUM_CH-1:0] a,
    output logic [NUM_CH-1:0] ack,
    input  logic              cfg_we,
    input  logic [ID_W-1:0]   cfg_id,
    input  logic [GAIN_W-1:0] cfg_gain,
    output logic              y,
    output logic              y_valid,
    output logic [ID_W-1:0]   y_id
);

    localparam int CW = COUNTER_SIZE + GAIN_W;
    localparam logic [CW-1:0]     ALPHA    = {{GAIN_W{1'b0}}, {COUNTER_SIZE{1'b1}}};
    localparam logic [GAIN_W-1:0] GAIN_RST = GAIN_W'(RESET_GAIN);
    localparam logic [ID_W-1:0]   RR_RST   = ID_W'(NUM_CH - 1);

    logic [CW-1:0]     counter_q [NUM_CH];
    logic [CW-1:0]     counter_d [NUM_CH];
    logic [GAIN_W-1:0] gain_q    [NUM_CH];
    logic [GAIN_W-1:0] gain_d    [NUM_CH];
    logic [ID_W-1:0]   rr_q, rr_d;
    logic              y_q, y_d;
    logic              y_valid_q, y_valid_d;
    logic [ID_W-1:0]   y_id_q, y_id_d;

    logic              grant_any;
    logic [ID_W-1:0]   grant_id;
    logic [ID_W-1:0]   cand_id;
    logic [CW-1:0]     sg;
    logic [CW-1:0]     c;
    logic              ybit;
    logic              cfg_id_ok;

    // Round-robin: scan from rr+1 upward (wrapping), first requester wins.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand_id   = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            cand_id = ID_W'((int'(rr_q) + k) % NUM_CH);
            if (!grant_any && req[cand_id]) begin
                grant_any = 1'b1;
                grant_id  = cand_id;
            end
        end
        if (!nRST) begin
            grant_any = 1'b0;
        end
        ack = '0;
        if (grant_any) begin
            ack[grant_id] = 1'b1;
        end
    end

    // One divide step on the granted context. Because counter < SG is kept,
    // c < SG + ALPHA which always fits in CW bits.
    always_comb begin
        sg   = ALPHA * {{COUNTER_SIZE{1'b0}}, gain_q[grant_id]};
        c    = counter_q[grant_id] + (a[grant_id] ? ALPHA : '0);
        ybit = (c >= sg);
    end

    assign cfg_id_ok = ({1'b0, cfg_id} < (ID_W + 1)'(NUM_CH));

    always_comb begin
        counter_d = counter_q;
        gain_d    = gain_q;
        rr_d      = rr_q;
        y_d       = 1'b0;
        y_valid_d = 1'b0;
        y_id_d    = y_id_q;

        if (grant_any) begin
            counter_d[grant_id] = ybit ? (c - sg) : c;
            rr_d                = grant_id;
            y_d                 = ybit;
            y_valid_d           = 1'b1;
            y_id_d              = grant_id;
        end

        // Applied after the grant update so a write to the granted channel
        // overrides its stored state, while y above used the old context.
        if (cfg_we && cfg_id_ok) begin
            gain_d[cfg_id]    = (cfg_gain == '0) ? GAIN_W'(1) : cfg_gain;
            counter_d[cfg_id] = '0;
        end

        if (!nRST) begin
            for (int i = 0; i < NUM_CH; i++) begin
                counter_d[i] = '0;
                gain_d[i]    = GAIN_RST;
            end
            rr_d      = RR_RST;
            y_d       = 1'b0;
            y_valid_d = 1'b0;
            y_id_d    = '0;
        end
    end

    always_ff @(posedge CLK) begin
        counter_q <= counter_d;
        gain_q    <= gain_d;
        rr_q      <= rr_d;
        y_q       <= y_d;
        y_valid_q <= y_valid_d;
        y_id_q    <= y_id_d;
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign y_id    = y_id_q;

endmodule

// File: tb/tb_stoch_div_scheduler.sv
module tb_stoch_div_scheduler;

    localparam int NCH = 4;

    logic       CLK = 1'b0;
    logic       nRST = 1'b0;
    logic [3:0] req = '0;
    logic [3:0] a = '0;
    logic [3:0] ack;
    logic       cfg_we = 1'b0;
    logic [1:0] cfg_id = '0;
    logic [7:0] cfg_gain = '0;
    logic       y;
    logic       y_valid;
    logic [1:0] y_id;

    stoch_div_scheduler #(
        .NUM_CH(4), .COUNTER_SIZE(8), .GAIN_W(8), .RESET_GAIN(2)
    ) dut (
        .CLK(CLK), .nRST(nRST), .req(req), .a(a), .ack(ack),
        .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_gain(cfg_gain),
        .y(y), .y_valid(y_valid), .y_id(y_id)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int failures = 0;

    // Reference model: per-channel residual and gain as plain integers.
    int m_cnt [NCH];
    int m_gain[NCH];
    int m_rr;
    int e_yv, e_y, e_yid;

    logic [3:0] ack_seen;
    logic       y_seen;

    typedef struct {
        logic [3:0] req;
        logic [3:0] a;
        logic [3:0] exp_ack;
        logic       exp_y;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i]  = 0;
            m_gain[i] = 2;
        end
        m_rr = NCH - 1;
    endtask

    // One clock: drive inputs after the falling edge, check ack, advance the
    // model, then check the registered outputs just after the rising edge.
    task automatic do_cycle(input logic [3:0] r, input logic [3:0] av,
                            input logic we, input logic [1:0] id,
                            input logic [7:0] g, input logic rn);
        int gid;
        int c;
        int sg;
        int eack;
        @(negedge CLK);
        req = r; a = av; cfg_we = we; cfg_id = id; cfg_gain = g; nRST = rn;
        #1;
        gid = -1;
        if (rn) begin
            for (int k = 1; k <= NCH; k++) begin
                if (gid < 0 && r[2'((m_rr + k) % NCH)]) gid = (m_rr + k) % NCH;
            end
        end
        eack = (gid < 0) ? 0 : (1 << gid);
        chk("ack", int'(ack), eack);
        ack_seen = ack;
        if (!rn) begin
            model_reset();
            e_yv = 0; e_y = 0; e_yid = 0;
        end else begin
            if (gid >= 0) begin
                c  = m_cnt[gid] + (av[2'(gid)] ? 255 : 0);
                sg = 255 * m_gain[gid];
                e_y = (c >= sg) ? 1 : 0;
                m_cnt[gid] = (e_y == 1) ? c - sg : c;
                m_rr  = gid;
                e_yv  = 1;
                e_yid = gid;
            end else begin
                e_yv = 0;
                e_y  = 0;
            end
            if (we) begin
                m_gain[id] = (g == 0) ? 1 : int'(g);
                m_cnt[id]  = 0;
            end
        end
        @(posedge CLK);
        #1;
        chk("y_valid", int'(y_valid), e_yv);
        chk("y", int'(y), e_y);
        chk("y_id", int'(y_id), e_yid);
        y_seen = y;
    endtask

    task automatic do_reset();
        do_cycle(4'b0000, 4'b0000, 1'b0, 2'd0, 8'd0, 1'b0);
    endtask

    logic [15:0] lfsr;
    logic        abit;
    int          ones;
    int          yones;
    logic [3:0]  rr4, ra4;
    logic        rwe, rrn;
    logic [1:0]  rid;
    logic [7:0]  rg;

    initial begin
        model_reset();
        e_yv = 0; e_y = 0; e_yid = 0;

        for (int i = 0; i < 6; i++) begin
            tbl[i].req = 4'b0001; tbl[i].a = 4'b0001;
            tbl[i].exp_ack = 4'b0001; tbl[i].exp_y = 1'(i % 2);
        end
        for (int i = 0; i < 8; i++) begin
            tbl[6+i].req = 4'b1111; tbl[6+i].a = 4'b1111;
            tbl[6+i].exp_ack = 4'(1 << (i % 4)); tbl[6+i].exp_y = (i >= 4);
        end

        do_reset();
        do_reset();

        // Single channel then all-channel interleaving, from the vector table.
        for (int i = 0; i < 14; i++) begin
            if (i == 6) do_reset();
            do_cycle(tbl[i].req, tbl[i].a, 1'b0, 2'd0, 8'd0, 1'b1);
            chk("tbl_ack", int'(ack_seen), int'(tbl[i].exp_ack));
            chk("tbl_y", int'(y_seen), int'(tbl[i].exp_y));
        end

        // Gain 3 on ch1 gives 0,0,1; gain 0 on ch2 is clamped to 1.
        do_reset();
        do_cycle(4'b0000, 4'b0000, 1'b1, 2'd1, 8'd3, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_cycle(4'b0010, 4'b0010, 1'b0, 2'd0, 8'd0, 1'b1);
            chk("gain3_pat", int'(y_seen), (i % 3 == 2) ? 1 : 0);
        end
        do_cycle(4'b0000, 4'b0000, 1'b1, 2'd2, 8'd0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(4'b0100, 4'b0100, 1'b0, 2'd0, 8'd0, 1'b1);
            chk("gain0_clamp", int'(y_seen), 1);
        end
        // Config on one channel while another is granted.
        do_cycle(4'b0001, 4'b0001, 1'b1, 2'd1, 8'd5, 1'b1);
        do_cycle(4'b0010, 4'b0010, 1'b0, 2'd0, 8'd0, 1'b1);

        // Config and grant on the same channel in the same cycle.
        do_reset();
        do_cycle(4'b0001, 4'b0001, 1'b0, 2'd0, 8'd0, 1'b1);
        do_cycle(4'b0001, 4'b0001, 1'b1, 2'd0, 8'd4, 1'b1);
        chk("cfg_same_y", int'(y_seen), 1);
        for (int i = 0; i < 4; i++) begin
            do_cycle(4'b0001, 4'b0001, 1'b0, 2'd0, 8'd0, 1'b1);
            chk("cfg_same_after", int'(y_seen), (i == 3) ? 1 : 0);
        end

        // LFSR stream on ch3, gain 2: exact output count and residual bound.
        do_reset();
        lfsr = 16'hACE1;
        ones = 0;
        yones = 0;
        for (int i = 0; i < 4096; i++) begin
            abit = lfsr[0];
            lfsr = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            do_cycle(4'b1000, {abit, 3'b000}, 1'b0, 2'd0, 8'd0, 1'b1);
            ones  += int'(abit);
            yones += int'(y_seen);
            chk("cnt_inv", (dut.counter_q[3] < 16'd510) ? 1 : 0, 1);
        end
        chk("lfsr_rate", yones, (ones * 255) / 510);

        // Randomized traffic, configuration and occasional resets.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            rr4 = 4'($urandom);
            ra4 = 4'($urandom);
            rwe = ($urandom_range(0, 7) == 0);
            rid = 2'($urandom);
            rg  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            rrn = ($urandom_range(0, 99) != 0);
            do_cycle(rr4, ra4, rwe, rid, rg, rrn);
        end

        // Mid-stream reset drops the in-flight result and restores contexts.
        do_reset();
        do_cycle(4'b0000, 4'b0000, 1'b1, 2'd1, 8'd5, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_cycle(4'b1111, 4'($urandom), 1'b0, 2'd0, 8'd0, 1'b1);
        end
        do_cycle(4'b1111, 4'b1111, 1'b0, 2'd0, 8'd0, 1'b0);
        chk("rst_ack", int'(ack_seen), 0);
        chk("rst_yv_dropped", int'(y_valid), 0);
        for (int i = 0; i < 8; i++) begin
            do_cycle(4'b1111, 4'b1111, 1'b0, 2'd0, 8'd0, 1'b1);
            chk("post_rst_ack", int'(ack_seen), 1 << (i % 4));
            chk("post_rst_y", int'(y_seen), (i >= 4) ? 1 : 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
